// File: rtl/umul_seq.sv
// Sequential unsigned shift-add multiply-accumulate: {AnswerTwo,AnswerOne} = A*B + C.
// Retires one multiplier bit per cycle, LSB first, so latency does not depend on the data.
module umul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] AnswerOne,
    output logic [WIDTH-1:0] AnswerTwo,
    output logic             Busy
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [2*WIDTH-1:0] ans;
    logic [SW-1:0]      step, step_next;
    logic [WIDTH:0]     sum;
    logic               load;

    // The partial sum never exceeds 2^(WIDTH+step+1), so a WIDTH+1 bit window
    // starting at the current bit position absorbs every carry.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        step_next  = step;
        load       = 1'b0;
        sum        = acc[step +: WIDTH+1] + {1'b0, mcand};
        case (state)
            IDLE: begin
                if (InValid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (mplier[step]) begin
                    acc_next[step +: WIDTH+1] = sum;
                end
                step_next = step + 1'b1;
                if (step == SW'(WIDTH-1)) begin
                    state_next = DONE;
                    load       = 1'b1;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            step   <= '0;
            ans    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && InValid) begin
                mplier <= A;
                mcand  <= B;
                acc    <= {{WIDTH{1'b0}}, C};
                step   <= '0;
            end else begin
                acc  <= acc_next;
                step <= step_next;
            end
            // Answers only change when a new product completes.
            if (load) begin
                ans <= acc_next;
            end
        end
    end

    assign InReady   = (state == IDLE);
    assign OutValid  = (state == DONE);
    assign Busy      = (state != IDLE);
    assign AnswerOne = ans[WIDTH-1:0];
    assign AnswerTwo = ans[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_umul_seq.sv
// Self-checking bench for umul_seq: table vectors, backpressure, mid-run reset and
// a back-to-back random stream, with results checked against a scoreboard queue.
module tb_umul_seq;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         InValid = 1'b0;
    logic         OutReady = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] C = '0;
    logic         InReady;
    logic         OutValid;
    logic         Busy;
    logic [W-1:0] AnswerOne;
    logic [W-1:0] AnswerTwo;

    umul_seq #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .B        (B),
        .C        (C),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .AnswerOne(AnswerOne),
        .AnswerTwo(AnswerTwo),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   c;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t        vecs[9];
    logic [63:0] sb[$];
    logic [63:0] expNext = '0;
    bit          useModel = 1'b0;
    bit          b2b = 1'b0;
    bit          havePrev = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          prevAccept = 0;
    int          acceptCount = 0;
    int          resultCount = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge Clk) cycle <= cycle + 1;

    // Scoreboard: push on every accepted operand set, pop on every result handshake.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (InValid && InReady) begin
                if (useModel) sb.push_back(64'(A) * 64'(B) + 64'(C));
                else sb.push_back(expNext);
                acceptCount++;
                if (b2b) begin
                    if (havePrev) checkOutput("issue interval", 64'(cycle - prevAccept), 64'd34);
                    prevAccept = cycle;
                    havePrev   = 1'b1;
                end
            end
            if (OutValid && OutReady) begin
                resultCount++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL result: got %0h expected no result", {AnswerTwo, AnswerOne});
                end else begin
                    checkOutput("result", {AnswerTwo, AnswerOne}, sb.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c, input logic [63:0] exp);
        int k = 0;
        while (!InReady && k < 100) begin
            @(posedge Clk); #1;
            k++;
        end
        if (!InReady) checkOutput("wait InReady", 64'(InReady), 64'd1);
        A       = a;
        B       = b;
        C       = c;
        expNext = exp;
        InValid = 1'b1;
        @(posedge Clk); #1;
        InValid = 1'b0;
    endtask

    // Cycles are counted from the cycle in which the operands were offered.
    task automatic waitOutValid(output int n);
        n = 1;
        while (!OutValid && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int startAcc;
        int startRes;
        int k;

        vecs[0] = '{32'd7,        32'd6,        32'd0,        64'd42};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000000};
        vecs[2] = '{32'd14,       32'd7,        32'd2,        64'd100};
        vecs[3] = '{32'd0,        32'd0,        32'd0,        64'd0};
        vecs[4] = '{32'd0,        32'hFFFFFFFF, 32'd5,        64'd5};
        vecs[5] = '{32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000001_FFFFFFFE};
        vecs[6] = '{32'h00010000, 32'h00010000, 32'd0,        64'h00000001_00000000};
        vecs[7] = '{32'hFFFFFFFF, 32'd2,        32'd1,        64'h00000001_FFFFFFFF};
        vecs[8] = '{32'h80000001, 32'd3,        32'd0,        64'h00000001_80000003};

        #12;
        checkOutput("reset InReady", 64'(InReady), 64'd1);
        checkOutput("reset OutValid", 64'(OutValid), 64'd0);
        checkOutput("reset Busy", 64'(Busy), 64'd0);
        checkOutput("reset answers", {AnswerTwo, AnswerOne}, 64'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;

        OutReady = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp);
            waitOutValid(n);
            checkOutput($sformatf("latency vec%0d", i), 64'(n), 64'd33);
        end

        // Backpressure: the result must hold and new operands must be refused.
        @(posedge Clk); #1;
        OutReady = 1'b0;
        applyStimulus(32'd3, 32'd5, 32'd0, 64'd15);
        waitOutValid(n);
        startAcc = acceptCount;
        for (int i = 0; i < 10; i++) begin
            A       = $urandom;
            B       = $urandom;
            C       = $urandom;
            InValid = 1'b1;
            @(posedge Clk); #1;
            checkOutput("hold OutValid", 64'(OutValid), 64'd1);
            checkOutput("hold InReady", 64'(InReady), 64'd0);
            checkOutput("hold answers", {AnswerTwo, AnswerOne}, 64'd15);
        end
        checkOutput("hold Busy", 64'(Busy), 64'd1);
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(posedge Clk); #1;
        checkOutput("release InReady", 64'(InReady), 64'd1);
        checkOutput("release OutValid", 64'(OutValid), 64'd0);
        checkOutput("ignored operands", 64'(acceptCount - startAcc), 64'd0);

        // Reset in the middle of a run discards the operation.
        applyStimulus(32'd3, 32'd5, 32'd0, 64'd15);
        repeat (9) @(posedge Clk);
        #2;
        checkOutput("pre-reset Busy", 64'(Busy), 64'd1);
        startRes = resultCount;
        Rst_n = 1'b0;
        #1;
        checkOutput("abort InReady", 64'(InReady), 64'd1);
        checkOutput("abort OutValid", 64'(OutValid), 64'd0);
        checkOutput("abort Busy", 64'(Busy), 64'd0);
        checkOutput("abort answers", {AnswerTwo, AnswerOne}, 64'd0);
        sb.delete();
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        applyStimulus(32'd9, 32'd9, 32'd1, 64'd82);
        waitOutValid(n);
        checkOutput("post-reset latency", 64'(n), 64'd33);
        @(posedge Clk); #1;
        checkOutput("post-reset results", 64'(resultCount - startRes), 64'd1);

        // Back-to-back stream with operands changing every cycle.
        useModel = 1'b1;
        havePrev = 1'b0;
        b2b      = 1'b1;
        startAcc = acceptCount;
        InValid  = 1'b1;
        k = 0;
        while (acceptCount - startAcc < 1000 && k < 40000) begin
            A = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            B = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            C = $urandom;
            @(posedge Clk); #1;
            k++;
        end
        InValid = 1'b0;
        b2b     = 1'b0;
        checkOutput("stream accepts", 64'(acceptCount - startAcc), 64'd1000);
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge Clk); #1;
            k++;
        end
        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
